// File: rtl/rv_pkg.sv
// Shared RVTU type definitions: divider op select and divider FSM states.
package rv_pkg;

  // Divider operation select: bit0 = unsigned, bit1 = remainder.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_fsel_t;

  // Shared divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // True when the op treats its operands as unsigned.
  function automatic logic fsel_is_unsigned(input div_fsel_t f);
    return f[0];
  endfunction

  // True when the op returns the remainder instead of the quotient.
  function automatic logic fsel_is_rem(input div_fsel_t f);
    return f[1];
  endfunction

endpackage

// File: rtl/rvtu_rr_arb.sv
// Combinational round-robin picker: grants the first eligible index strictly
// after last_grant_i, wrapping modulo N. Reusable by any shared RVTU unit.
module rvtu_rr_arb #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [IDXW-1:0] last_grant_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            valid_o
);

  // Scan N candidates starting one past the previous winner.
  always_comb begin : pick
    int cand;
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value held over from a previous evaluation and no latch is inferred.
    // Blocking assignments are correct here: the scan is a chain of
    // combinational priority decisions evaluated in order within one cycle.
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    cand        = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_grant_i) + off;
      if (cand >= N) cand = cand - N;
      if (!valid_o && eligible_i[cand]) begin
        valid_o       = 1'b1;
        grant_idx_o   = IDXW'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvtu_div_arb_n.sv
// N-client arbitrated iterative divider (RV32M DIV/DIVU/REM/REMU).
// One shared radix-2^UNROLL restoring datapath; round-robin client selection,
// per-client kill, early-out for divide-by-zero and signed overflow.
module rvtu_div_arb_n
  import rv_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int XLEN        = 32,
  parameter int UNROLL      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CLIENTS-1:0]      req_i,
  input  logic [NUM_CLIENTS*XLEN-1:0] src1_i,
  input  logic [NUM_CLIENTS*XLEN-1:0] src2_i,
  input  logic [NUM_CLIENTS*2-1:0]    fsel_i,
  input  logic [NUM_CLIENTS-1:0]      kill_i,
  output logic [NUM_CLIENTS-1:0]      resp_o,
  output logic [XLEN-1:0]             out_o,
  output logic                        busy_o
);

  localparam int IDXW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int STEPS = XLEN / UNROLL;
  localparam int CNTW  = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  // Control and datapath state.
  div_state_t             state_q;
  logic [IDXW-1:0]        last_grant_q;
  logic [IDXW-1:0]        grant_idx_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  div_fsel_t              fsel_q;
  logic [CNTW-1:0]        count_q;
  logic [XLEN-1:0]        quo_q;   // dividend shifts out as quotient shifts in
  logic [XLEN:0]          rem_q;   // partial remainder, one guard bit
  logic [XLEN-1:0]        div_q;   // divisor magnitude
  logic                   neg_quo_q;
  logic                   neg_rem_q;

  // Arbitration among requesting, non-killed clients.
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] arb_grant;
  logic [IDXW-1:0]        arb_idx;
  logic                   arb_valid;

  assign eligible = req_i & ~kill_i;

  rvtu_rr_arb #(
    .N    (NUM_CLIENTS),
    .IDXW (IDXW)
  ) u_arb (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .valid_o      (arb_valid)
  );

  // Candidate operands of the client the arbiter would pick this cycle.
  logic [XLEN-1:0] a_src1, a_src2, a_abs1, a_abs2;
  logic [1:0]      a_fsel;
  logic            a_signed, a_s1neg, a_s2neg, a_div0, a_ovf;

  assign a_src1   = src1_i[arb_idx*XLEN +: XLEN];
  assign a_src2   = src2_i[arb_idx*XLEN +: XLEN];
  assign a_fsel   = fsel_i[arb_idx*2 +: 2];
  assign a_signed = ~fsel_is_unsigned(div_fsel_t'(a_fsel));
  assign a_s1neg  = a_signed & a_src1[XLEN-1];
  assign a_s2neg  = a_signed & a_src2[XLEN-1];
  // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(XLEN-1).
  assign a_abs1   = a_s1neg ? -a_src1 : a_src1;
  assign a_abs2   = a_s2neg ? -a_src2 : a_src2;
  assign a_div0   = (a_src2 == '0);
  assign a_ovf    = a_signed && (a_src1 == MIN_VAL) && (a_src2 == '1);

  // UNROLL chained restoring steps: shift, trial-subtract, keep if no borrow.
  logic [XLEN-1:0] quo_n;
  logic [XLEN:0]   rem_n;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_n = quo_q;
    rem_n = rem_q;
    trial = '0;
    for (int k = 0; k < UNROLL; k++) begin
      rem_n = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      trial = rem_n - {1'b0, div_q};
      if (!trial[XLEN]) begin
        rem_n    = trial;
        quo_n[0] = 1'b1;
      end
    end
  end

  // Control FSM plus operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDXW'(NUM_CLIENTS - 1);
      grant_idx_q  <= '0;
      grant_q      <= '0;
      fsel_q       <= DIV;
      count_q      <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_idx_q <= arb_idx;
            grant_q     <= arb_grant;
            fsel_q      <= div_fsel_t'(a_fsel);
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            if (a_div0) begin
              quo_q   <= '1;
              rem_q   <= {1'b0, a_src1};
              state_q <= DONE;
            end else if (a_ovf) begin
              quo_q   <= MIN_VAL;
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              quo_q     <= a_abs1;
              rem_q     <= '0;
              div_q     <= a_abs2;
              count_q   <= CNTW'(STEPS);
              neg_quo_q <= a_s1neg ^ a_s2neg;
              neg_rem_q <= a_s1neg;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          if (kill_i[grant_idx_q]) begin
            state_q      <= IDLE;
            last_grant_q <= grant_idx_q;
          end else begin
            quo_q   <= quo_n;
            rem_q   <= rem_n;
            count_q <= count_q - 1'b1;
            if (count_q == CNTW'(1)) state_q <= DONE;
          end
        end
        DONE: begin
          // Completion and kill both retire the grantee; only resp differs.
          state_q      <= IDLE;
          last_grant_q <= grant_idx_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sign-corrected result, presented only during an unkilled DONE cycle.
  logic [XLEN-1:0] q_fix, r_fix;
  logic            done_ok;

  assign q_fix   = neg_quo_q ? -quo_q : quo_q;
  assign r_fix   = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign done_ok = (state_q == DONE) && !kill_i[grant_idx_q];
  assign resp_o  = done_ok ? grant_q : '0;
  assign out_o   = done_ok ? (fsel_is_rem(fsel_q) ? r_fix : q_fix) : '0;
  assign busy_o  = (state_q != IDLE);

  // The grantee must hold req until resp unless it kills its operation.
  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE && !kill_i[grant_idx_q]) |-> req_i[grant_idx_q]);

  // At most one client completes per cycle.
  a_resp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(resp_o));

endmodule

// File: tb/tb_rvtu_div_arb_n.sv
// Directed bench for rvtu_div_arb_n with hand-computed expected results.
module tb_rvtu_div_arb_n;

  localparam int N    = 4;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, kill;
  logic [N*XLEN-1:0] src1, src2;
  logic [N*2-1:0]    fsel;
  logic [N-1:0]      resp;
  logic [XLEN-1:0]   out_v;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [31:0] exp;
    string       name;
  } vec_t;

  rvtu_div_arb_n #(.NUM_CLIENTS(N), .XLEN(XLEN), .UNROLL(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .src1_i (src1),
    .src2_i (src2),
    .fsel_i (fsel),
    .kill_i (kill),
    .resp_o (resp),
    .out_o  (out_v),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  // Hold reset for two edges; leaves time at #1 after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    kill  = '0;
    src1  = '0;
    src2  = '0;
    fsel  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] f);
    src1[idx*XLEN +: XLEN] = a;
    src2[idx*XLEN +: XLEN] = b;
    fsel[idx*2 +: 2]       = f;
  endtask

  // Count falling edges until resp appears; n=0 is the cycle req was raised in.
  task automatic wait_resp(input int budget, output int lat, output logic [N-1:0] r,
                           output logic [XLEN-1:0] o, output logic b, output bit to);
    lat = 0; r = '0; o = '0; b = 1'b0; to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (resp != '0) begin
        lat = n; r = resp; o = out_v; b = busy; to = 1'b0;
        break;
      end
    end
  endtask

  // Drop req in the IDLE cycle after resp, then let one more edge pass.
  task automatic finish_op(input int idx);
    @(posedge clk);
    #1 req[idx] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (resp !== '0) begin errors++; $display("FAIL reset_resp got %b expected 0", resp); end
    checks++;
    if (out_v !== '0) begin errors++; $display("FAIL reset_out got %h expected 0", out_v); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    vec_t tbl[$];
    int lat; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    logic [N-1:0] exp_r;
    tbl.push_back('{0, 32'hFFFFFFF9, 32'h00000002, 2'b00, 32'hFFFFFFFD, "div_-7_2"});
    tbl.push_back('{0, 32'hFFFFFFF9, 32'h00000002, 2'b10, 32'hFFFFFFFF, "rem_-7_2"});
    tbl.push_back('{2, 32'hFFFFFFFF, 32'h00000010, 2'b01, 32'h0FFFFFFF, "divu_max_16"});
    tbl.push_back('{2, 32'hFFFFFFFF, 32'h00000010, 2'b11, 32'h0000000F, "remu_max_16"});
    tbl.push_back('{1, 32'h00000007, 32'hFFFFFFFE, 2'b00, 32'hFFFFFFFD, "div_7_-2"});
    tbl.push_back('{1, 32'h00000007, 32'hFFFFFFFE, 2'b10, 32'h00000001, "rem_7_-2"});
    tbl.push_back('{0, 32'hFFFFFFF9, 32'hFFFFFFFE, 2'b00, 32'h00000003, "div_-7_-2"});
    tbl.push_back('{0, 32'hFFFFFFF9, 32'hFFFFFFFE, 2'b10, 32'hFFFFFFFF, "rem_-7_-2"});
    tbl.push_back('{3, 32'h80000000, 32'h00000002, 2'b00, 32'hC0000000, "div_min_2"});
    tbl.push_back('{3, 32'h80000000, 32'hFFFFFFFF, 2'b01, 32'h00000000, "divu_min_max"});
    tbl.push_back('{3, 32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000, "remu_min_max"});
    foreach (tbl[i]) begin
      exp_r = '0;
      exp_r[tbl[i].idx] = 1'b1;
      set_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].f);
      req[tbl[i].idx] = 1'b1;
      wait_resp(40, lat, r, o, b, to);
      checks++;
      if (to || lat != 17) begin
        errors++; $display("FAIL %s latency got %0d (timeout %0d) expected 17", tbl[i].name, lat, to);
      end
      checks++;
      if (o !== tbl[i].exp) begin
        errors++; $display("FAIL %s out got %h expected %h", tbl[i].name, o, tbl[i].exp);
      end
      checks++;
      if (r !== exp_r) begin
        errors++; $display("FAIL %s resp got %b expected %b", tbl[i].name, r, exp_r);
      end
      checks++;
      if (b !== 1'b1) begin
        errors++; $display("FAIL %s busy_done got %b expected 1", tbl[i].name, b);
      end
      finish_op(tbl[i].idx);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL %s busy_after got %b expected 0", tbl[i].name, busy);
      end
    end
  endtask

  task automatic test_special();
    vec_t tbl[$];
    int lat; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    logic [N-1:0] exp_r;
    tbl.push_back('{0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000, "div_ovf"});
    tbl.push_back('{0, 32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h00000000, "rem_ovf"});
    tbl.push_back('{1, 32'h00000005, 32'h00000000, 2'b01, 32'hFFFFFFFF, "divu_5_0"});
    tbl.push_back('{1, 32'h00000005, 32'h00000000, 2'b11, 32'h00000005, "remu_5_0"});
    tbl.push_back('{2, 32'hFFFFFFFB, 32'h00000000, 2'b00, 32'hFFFFFFFF, "div_-5_0"});
    tbl.push_back('{2, 32'hFFFFFFFB, 32'h00000000, 2'b10, 32'hFFFFFFFB, "rem_-5_0"});
    foreach (tbl[i]) begin
      exp_r = '0;
      exp_r[tbl[i].idx] = 1'b1;
      set_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].f);
      req[tbl[i].idx] = 1'b1;
      wait_resp(40, lat, r, o, b, to);
      checks++;
      if (to || lat != 1) begin
        errors++; $display("FAIL %s latency got %0d (timeout %0d) expected 1", tbl[i].name, lat, to);
      end
      checks++;
      if (o !== tbl[i].exp) begin
        errors++; $display("FAIL %s out got %h expected %h", tbl[i].name, o, tbl[i].exp);
      end
      checks++;
      if (r !== exp_r) begin
        errors++; $display("FAIL %s resp got %b expected %b", tbl[i].name, r, exp_r);
      end
      finish_op(tbl[i].idx);
    end
  endtask

  // All clients request continuously: strict rotation, one op per 18 cycles.
  task automatic test_fairness();
    int lat, gap; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_r;
    apply_reset();
    for (int c = 0; c < N; c++) set_op(c, 32'd100, 32'd7, 2'b01);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_resp(40, lat, r, o, b, to);
      gap   = (k == 0) ? lat : lat + 1;
      exp_r = '0;
      exp_r[order[k]] = 1'b1;
      checks++;
      if (to || gap != ((k == 0) ? 17 : 18)) begin
        errors++; $display("FAIL rr_gap%0d got %0d (timeout %0d) expected %0d", k, gap, to, (k == 0) ? 17 : 18);
      end
      checks++;
      if (r !== exp_r) begin
        errors++; $display("FAIL rr_grant%0d got %b expected %b", k, r, exp_r);
      end
      checks++;
      if (o !== 32'd14) begin
        errors++; $display("FAIL rr_out%0d got %0d expected 14", k, o);
      end
    end
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1;
  endtask

  // Kill of the grantee mid-RUN, then the pending client wins next IDLE.
  task automatic test_kill_run();
    int lat; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    apply_reset();
    set_op(1, 32'd100, 32'd7, 2'b01);
    set_op(2, 32'd100, 32'd7, 2'b01);
    req = 4'b0110;
    repeat (5) @(posedge clk);
    #1 kill[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (resp !== '0) begin errors++; $display("FAIL kill_run_resp got %b expected 0", resp); end
    @(posedge clk);
    #1 kill[1] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_run_busy got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL kill_next_busy got %b expected 1", busy); end
    wait_resp(40, lat, r, o, b, to);
    checks++;
    if (to || lat != 15 || r !== 4'b0100) begin
      errors++; $display("FAIL kill_next_grant got %b lat %0d (timeout %0d) expected 0100 lat 15", r, lat, to);
    end
    checks++;
    if (o !== 32'd14) begin errors++; $display("FAIL kill_next_out got %0d expected 14", o); end
    finish_op(2);
  endtask

  // Kill arriving in the DONE cycle suppresses the completion.
  task automatic test_kill_done();
    set_op(0, 32'd100, 32'd7, 2'b01);
    req[0] = 1'b1;
    repeat (17) @(posedge clk);
    #1 kill[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL kill_done_state got busy %b expected 1", busy); end
    checks++;
    if (resp !== '0 || out_v !== '0) begin
      errors++; $display("FAIL kill_done_resp got resp %b out %h expected 0 0", resp, out_v);
    end
    @(posedge clk);
    #1 kill[0] = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_done_busy got %b expected 0", busy); end
    @(posedge clk);
    #1;
  endtask

  // Kill on a non-grantee only removes it from arbitration.
  task automatic test_kill_mask();
    int lat; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    apply_reset();
    set_op(0, 32'd50, 32'd5, 2'b01);
    set_op(1, 32'd100, 32'd7, 2'b11);
    kill = 4'b0001;
    req  = 4'b0011;
    wait_resp(40, lat, r, o, b, to);
    checks++;
    if (to || r !== 4'b0010 || lat != 17) begin
      errors++; $display("FAIL mask_grant got %b lat %0d (timeout %0d) expected 0010 lat 17", r, lat, to);
    end
    checks++;
    if (o !== 32'd2) begin errors++; $display("FAIL mask_out got %0d expected 2", o); end
    @(posedge clk);
    #1 req = '0;
    kill = '0;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-RUN, then client 0 wins and completes cleanly.
  task automatic test_reset_mid_run();
    int lat; logic [N-1:0] r; logic [XLEN-1:0] o; logic b; bit to;
    apply_reset();
    set_op(1, 32'd100, 32'd7, 2'b01);
    req[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp !== '0 || out_v !== '0) begin
      errors++; $display("FAIL rst_mid got busy %b resp %b out %h expected 0 0 0", busy, resp, out_v);
    end
    @(posedge clk);
    #1 req = '0;
    set_op(0, 32'hFFFFFFF9, 32'h00000002, 2'b00);
    rst_n = 1'b1;
    req = 4'b0011;
    wait_resp(40, lat, r, o, b, to);
    checks++;
    if (to || r !== 4'b0001 || lat != 17) begin
      errors++; $display("FAIL rst_first_grant got %b lat %0d (timeout %0d) expected 0001 lat 17", r, lat, to);
    end
    checks++;
    if (o !== 32'hFFFFFFFD) begin errors++; $display("FAIL rst_first_out got %h expected fffffffd", o); end
    finish_op(0);
    wait_resp(40, lat, r, o, b, to);
    checks++;
    if (to || r !== 4'b0010 || o !== 32'd14) begin
      errors++; $display("FAIL rst_second got resp %b out %0d (timeout %0d) expected 0010 14", r, o, to);
    end
    finish_op(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_final_busy got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_fairness();
    test_kill_run();
    test_kill_done();
    test_kill_mask();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
